// File: rtl/isa_pkg.sv
// Shared ISA-level constants and types for the register-file writeback path.
//   DATA_W / NREG / REG_W : data width, architectural register count, index width
//   REQ_A / REQ_B         : requester ids, also the encoding of the round-robin pointer
//   wr_req_t              : one register-file write request {dst, data}
package isa_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int REG_W  = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Per-register pending-write scoreboard.
// Issue-time reservations (alloc) raise a register's count, committed writes
// (the registered register-file strobe) lower it. busy[i] flags a nonzero count.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   alloc_valid, alloc_reg    : reservation request
//   alloc_ready               : reservation accepted (count for alloc_reg not saturated)
//   commit_valid, commit_reg  : committed write (rf_RegWrite, rf_select3)
//   busy                      : one bit per register, registered-state only
module reg_pending_scoreboard #(
  parameter int NREG  = isa_pkg::NREG,
  parameter int REG_W = isa_pkg::REG_W,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [REG_W-1:0] alloc_reg,
  output logic             alloc_ready,
  input  logic             commit_valid,
  input  logic [REG_W-1:0] commit_reg,
  output logic [NREG-1:0]  busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] count;
  logic [NREG-1:0]            inc;
  logic [NREG-1:0]            dec;
  logic                       alloc_fire;

  assign alloc_ready = (count[alloc_reg] != CNT_MAX);
  assign alloc_fire  = alloc_valid && alloc_ready;

  // A commit to a register with no reservation outstanding is ignored so the
  // count can never wrap below zero.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = alloc_fire && (alloc_reg == REG_W'(i));
      dec[i] = commit_valid && (commit_reg == REG_W'(i)) && (count[i] != '0);
    end
  end

  // Simultaneous reserve and commit on the same register cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        count[i] <= '0;
      end else if (inc[i] && !dec[i]) begin
        count[i] <= count[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i] = |count[i];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between two writeback requesters
// (A = ALU result, B = memory load) with round-robin arbitration, and tracks
// outstanding writes per register for the decode-stage hazard logic.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   a_valid/a_ready/a_reg/a_data      : requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data      : requester B handshake and payload
//   alloc_valid/alloc_reg/alloc_ready : issue-time destination reservation
//   rf_select3/rf_RegWrite/rf_RegDst/rf_WriteData : registered register-file write port
//   busy                              : per-register pending-write flag
module regfile_write_arbiter #(
  parameter int DATA_W = isa_pkg::DATA_W,
  parameter int NREG   = isa_pkg::NREG,
  parameter int REG_W  = isa_pkg::REG_W,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_reg,
  output logic              alloc_ready,
  output logic [REG_W-1:0]  rf_select3,
  output logic              rf_RegWrite,
  output logic              rf_RegDst,
  output logic [DATA_W-1:0] rf_WriteData,
  output logic [NREG-1:0]   busy
);

  import isa_pkg::*;

  logic    ptr;
  logic    grant_a;
  logic    grant_b;
  logic    grant;
  wr_req_t win;

  // Under contention ptr names the preferred requester; an uncontended
  // requester is always granted.
  always_comb begin
    grant_a = a_valid && (!b_valid || (ptr == REQ_A));
    grant_b = b_valid && (!a_valid || (ptr == REQ_B));
    grant   = grant_a || grant_b;
    win     = '{dst: b_reg, data: b_data};
    if (grant_a) begin
      win = '{dst: a_reg, data: a_data};
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Write port: strobe for one cycle per grant; select/data hold between writes.
  // A grant coinciding with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= REQ_A;
      rf_RegWrite  <= 1'b0;
      rf_RegDst    <= 1'b0;
      rf_select3   <= '0;
      rf_WriteData <= '0;
    end else begin
      rf_RegWrite <= grant;
      rf_RegDst   <= grant;
      if (grant) begin
        rf_select3   <= win.dst;
        rf_WriteData <= win.data;
      end
      if (grant_a) begin
        ptr <= REQ_B;
      end else if (grant_b) begin
        ptr <= REQ_A;
      end
    end
  end

  reg_pending_scoreboard #(
    .NREG  (NREG),
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_reg    (alloc_reg),
    .alloc_ready  (alloc_ready),
    .commit_valid (rf_RegWrite),
    .commit_reg   (rf_select3),
    .busy         (busy)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a cycle model predicts grants,
// pending counts and the write port; granted writes are queued and compared
// when the register-file strobe appears.
module tb_regfile_write_arbiter;
  import isa_pkg::*;

  localparam int CMAX = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, alloc_valid;
  logic              a_ready, b_ready, alloc_ready;
  logic [REG_W-1:0]  a_reg, b_reg, alloc_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic [REG_W-1:0]  rf_select3;
  logic              rf_RegWrite, rf_RegDst;
  logic [DATA_W-1:0] rf_WriteData;
  logic [NREG-1:0]   busy;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .alloc_valid  (alloc_valid),
    .alloc_reg    (alloc_reg),
    .alloc_ready  (alloc_ready),
    .rf_select3   (rf_select3),
    .rf_RegWrite  (rf_RegWrite),
    .rf_RegDst    (rf_RegDst),
    .rf_WriteData (rf_WriteData),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  wr_req_t           exp_q[$];
  logic              m_init = 1'b0;
  logic              m_ptr, m_we;
  logic [REG_W-1:0]  m_sel;
  logic [DATA_W-1:0] m_data;
  int                m_cnt[NREG];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    alloc_valid = 1'b0; alloc_reg = '0;
  endtask

  // One clock: check combinational readies before the edge, advance the model
  // at the edge, then check registered outputs just after it.
  task automatic tick();
    logic ea, eb, er;
    logic [NREG-1:0] m_busy;
    wr_req_t w;
    bit inc, dec;
    @(negedge clk);
    ea = a_valid && (!b_valid || !m_ptr);
    eb = b_valid && (!a_valid || m_ptr);
    er = (m_cnt[alloc_reg] != CMAX);
    if (m_init) begin
      check_eq("a_ready", a_ready, ea);
      check_eq("b_ready", b_ready, eb);
      check_eq("alloc_ready", alloc_ready, er);
    end
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1;
      m_ptr = 1'b0; m_we = 1'b0; m_sel = '0; m_data = '0;
      for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < NREG; i++) begin
        inc = alloc_valid && er && (int'(alloc_reg) == i);
        dec = m_we && (int'(m_sel) == i) && (m_cnt[i] > 0);
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) m_cnt[i]--;
      end
      if (ea) begin
        m_we = 1'b1; m_sel = a_reg; m_data = a_data; m_ptr = 1'b1;
        w.dst = a_reg; w.data = a_data; exp_q.push_back(w);
      end else if (eb) begin
        m_we = 1'b1; m_sel = b_reg; m_data = b_data; m_ptr = 1'b0;
        w.dst = b_reg; w.data = b_data; exp_q.push_back(w);
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NREG; i++) m_busy[i] = (m_cnt[i] != 0);
    check_eq("rf_RegWrite", rf_RegWrite, m_we);
    check_eq("rf_RegDst", rf_RegDst, m_we);
    check_eq("rf_select3_hold", rf_select3, m_sel);
    check_eq("rf_WriteData_hold", rf_WriteData, m_data);
    check_eq("busy", busy, m_busy);
    if (rf_RegWrite === 1'b1) begin
      check_eq("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check_eq("wr_select", rf_select3, w.dst);
        check_eq("wr_data", rf_WriteData, w.data);
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] t3_data[4];
    t3_data[0] = 16'h1111; t3_data[1] = 16'h2222;
    t3_data[2] = 16'h1111; t3_data[3] = 16'h2222;

    // 1. reset
    idle();
    rst = 1'b1;
    tick(); tick();
    check_eq("rst_RegWrite", rf_RegWrite, 0);
    check_eq("rst_RegDst", rf_RegDst, 0);
    check_eq("rst_busy", busy, 16'h0000);
    check_eq("rst_alloc_ready", alloc_ready, 1);
    rst = 1'b0;

    // 2. single request
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h35A5;
    tick();
    check_eq("t2_strobe", rf_RegWrite, 1);
    check_eq("t2_dst", rf_RegDst, 1);
    check_eq("t2_sel", rf_select3, 5);
    check_eq("t2_data", rf_WriteData, 16'h35A5);
    idle();
    tick();
    check_eq("t2_strobe_off", rf_RegWrite, 0);

    // 3. contention on reg 3 held valid from reset
    rst = 1'b1;
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h2222;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t3_order", rf_WriteData, t3_data[k]);
    end
    idle();
    tick();

    // 4. scoreboard on reg 7
    alloc_valid = 1'b1; alloc_reg = 4'd7;
    tick();
    check_eq("t4_busy_alloc", busy[7], 1);
    tick();
    alloc_valid = 1'b0;
    b_valid = 1'b1; b_reg = 4'd7; b_data = 16'h7777;
    tick();
    b_data = 16'h7778;
    tick();
    check_eq("t4_busy_after_first", busy[7], 1);
    idle();
    tick();
    check_eq("t4_busy_cleared", busy[7], 0);

    // 5. saturation and simultaneous alloc/commit on reg 2
    alloc_valid = 1'b1; alloc_reg = 4'd2;
    tick(); tick(); tick();
    check_eq("t5_saturated", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0;
    b_valid = 1'b1; b_reg = 4'd2; b_data = 16'h2A2A;
    tick();
    b_data = 16'h2B2B;
    tick();
    b_valid = 1'b0;
    alloc_valid = 1'b1; alloc_reg = 4'd2;
    tick();
    check_eq("t5_count_unchanged", alloc_ready, 1);
    tick();
    check_eq("t5_resaturated", alloc_ready, 0);
    idle();
    tick();

    // 6. reset mid-operation
    alloc_valid = 1'b1; alloc_reg = 4'd9;
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h0909;
    tick();
    alloc_valid = 1'b0;
    a_data = 16'h0A0A;
    rst = 1'b1;
    tick();
    check_eq("t6_no_strobe", rf_RegWrite, 0);
    check_eq("t6_busy", busy, 16'h0000);
    rst = 1'b0;
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'hAAAA;
    b_valid = 1'b1; b_reg = 4'd4; b_data = 16'hBBBB;
    #1;
    check_eq("t6_a_wins", a_ready, 1);
    tick();
    idle();
    tick(); tick();

    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (select3/RegWrite/RegDst/WriteData) between two writeback requesters: A = ALU result, B = memory load.
- Round-robin arbitration with valid/ready handshakes; registered write outputs drive the register file directly.
- Keeps a per-register pending-write scoreboard, filled by issue-time reservations and drained by committed writes.
- The busy vector feeds hazard/stall logic in the decode stage.

Parameters:
DATA_W, 16, register data width
NREG, 16, number of architectural registers
REG_W, 4, register index width (log2 NREG)
CNT_W, 2, pending-write counter width per register (max outstanding = 2^CNT_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
a_valid  in  1  requester A has a write pending
a_ready  out  1  A granted this cycle (combinational)
a_reg  in  REG_W  A destination register
a_data  in  DATA_W  A write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B granted this cycle (combinational)
b_reg  in  REG_W  B destination register
b_data  in  DATA_W  B write data
alloc_valid  in  1  issue stage reserves a destination register
alloc_reg  in  REG_W  register being reserved
alloc_ready  out  1  reservation accepted (counter for alloc_reg not saturated)
rf_select3  out  REG_W  register file write select
rf_RegWrite  out  1  register file write enable
rf_RegDst  out  1  register file destination select, equal to 1 whenever rf_RegWrite=1, else 0
rf_WriteData  out  DATA_W  register file write data
busy  out  NREG  busy[i]=1 iff register i has a nonzero pending count

Behaviour:
- Reset (rst=1 at an edge):
  - rf_RegWrite=0, rf_RegDst=0, rf_select3=0, rf_WriteData=0.
  - ptr=0 (A preferred); all pending counters=0, so busy=0.
  - Reset mid-transfer discards the pending write; the registered write for the cycle after a reset edge is suppressed.
- Arbitration (combinational, same cycle as valid):
  - Only A valid -> a_ready=1. Only B valid -> b_ready=1.
  - Both valid -> grant the requester indicated by ptr (0=A, 1=B).
  - At most one ready is high per cycle; ready is never high without its own valid.
- Pointer:
  - After any grant, ptr points to the non-granted requester.
  - With no grant, ptr holds.
  - Worst-case wait under continuous contention is 1 cycle.
- Transfer:
  - On valid&ready, the next edge registers rf_select3/rf_WriteData from the winner and sets rf_RegWrite=1, rf_RegDst=1.
  - Latency from handshake to write strobe is 1 cycle.
  - rf_RegWrite is high for exactly one cycle per transfer; back-to-back transfers give a continuous strobe.
  - With no transfer, rf_RegWrite=0 and rf_RegDst=0; select/data hold their last value.
- Same-register collision: if A and B target the same register in the same cycle, the loser writes later, so the loser's data is the final value.
- Scoreboard, per register:
  - Counter increments when alloc_valid&alloc_ready targets it.
  - Counter decrements in the cycle rf_RegWrite=1 with rf_select3 equal to that register.
  - Increment and decrement in the same cycle on the same register -> count unchanged.
  - Decrement at count 0 is ignored (write without reservation); the count never wraps below 0.
  - alloc_ready=0 when count[alloc_reg]=2^CNT_W-1; no increment then. The count never wraps above max.
  - busy is the OR-reduction of each register's count, updated on the edge (no combinational path from inputs).
- No special handling of register 0; every index is writable.

Decomposition:
- Shared package `isa_pkg`:
  - Constants DATA_W=16, NREG=16, REG_W=4.
  - Requester-id encoding REQ_A=0, REQ_B=1.
  - Typedef for a write request {reg, data}.
- One natural sub-module, `reg_pending_scoreboard`: the counter array, alloc_ready and busy generation. Inputs are the alloc pair and the commit pair (rf_RegWrite, rf_select3).
- Arbiter and output register stay in the top module.

Test Plan:
1. Reset check: hold rst 2 cycles -> rf_RegWrite=0, rf_RegDst=0, busy=16'h0000, alloc_ready=1.
2. Single request: a_valid=1, a_reg=5, a_data=16'h35A5 for one cycle -> a_ready=1 that cycle; the next cycle gives rf_RegWrite=1, rf_RegDst=1, rf_select3=5, rf_WriteData=16'h35A5; one cycle later rf_RegWrite=0.
3. Contention: A(reg 3, 16'h1111) and B(reg 3, 16'h2222) held valid from reset ->
   - cycle 0: A granted;
   - cycle 1: B granted;
   - writes seen are reg3=1111 then reg3=2222;
   - ptr alternates under continuous valid (A,B,A,B over 4 cycles).
4. Scoreboard: alloc reg 7 twice, then B writes reg 7 twice ->
   - busy[7]=1 after the first alloc;
   - busy[7] stays 1 after the first commit;
   - busy[7]=0 the cycle after the second rf_RegWrite.
5. Saturation/simultaneity:
   - Alloc reg 2 three times -> alloc_ready=0 on the 4th attempt; count stays 3.
   - Alloc reg 2 in the same cycle a reg-2 commit strobes -> count unchanged.
6. Reset mid-operation: a_valid granted, then rst asserted at the next edge -> no rf_RegWrite strobe, busy=0, ptr=0 (A wins the next contention).
